// File: rtl/exec_trace_buffer.sv
// exec_trace_buffer: captures processor retirement outputs into a sequence-numbered
// FWFT record FIFO, drained over a valid/ready port; drops on full are counted.
module exec_trace_buffer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              capture_en,
  input  logic [31:0]       program_counter,
  input  logic [31:0]       instruction,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       reg_mem,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_alu,
  output logic [31:0]       out_reg,
  output logic [15:0]       out_seq,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic [15:0]       overflow_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned SEQ_W = 16;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic [31:0]      alu;
    logic [31:0]      wb;
  } rec_t;

  rec_t              r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic              r_empty;
  logic [SEQ_W-1:0]  r_seq;
  logic [15:0]       r_ovf;

  logic              w_pop;
  logic              w_wr_en;
  logic              w_drop;
  logic [CNT_W-1:0]  w_count_nxt;
  rec_t              w_head;

  // Handshake decode: a push is accepted unless full, and a simultaneous pop frees a slot
  always_comb begin
    w_pop   = !r_empty && out_ready;
    w_wr_en = capture_en && (!r_full || w_pop);
    w_drop  = capture_en && r_full && !w_pop;
    w_count_nxt = r_count;
    case ({w_wr_en, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointer, occupancy, sequence and drop-counter state
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_seq    <= '0;
      r_ovf    <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
      if (capture_en) r_seq <= r_seq + SEQ_W'(1);
      if (w_drop && (r_ovf != 16'hFFFF)) r_ovf <= r_ovf + 16'd1;
    end
  end

  // Record storage; no reset needed since occupancy gates visibility
  always_ff @(posedge clock) begin
    if (reset && w_wr_en) begin
      r_mem[r_wr_ptr] <= '{seq: r_seq, pc: program_counter, instr: instruction,
                           alu: alu_result, wb: reg_mem};
    end
  end

  // First-word-fall-through head, forced to zero when empty
  always_comb begin
    w_head    = r_empty ? '0 : r_mem[r_rd_ptr];
    out_valid = !r_empty;
    out_pc    = w_head.pc;
    out_instr = w_head.instr;
    out_alu   = w_head.alu;
    out_reg   = w_head.wb;
    out_seq   = w_head.seq;
  end

  assign count          = r_count;
  assign full           = r_full;
  assign empty          = r_empty;
  assign overflow_count = r_ovf;

endmodule

// File: tb/tb_exec_trace_buffer.sv
// Bench for exec_trace_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_exec_trace_buffer;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        capture_en;
  logic [31:0] program_counter, instruction, alu_result, reg_mem;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr, out_alu, out_reg;
  logic [15:0] out_seq;
  logic [ADDR_W:0] count;
  logic        full, empty;
  logic [15:0] overflow_count;

  exec_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .capture_en(capture_en),
    .program_counter(program_counter), .instruction(instruction),
    .alu_result(alu_result), .reg_mem(reg_mem),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_alu(out_alu), .out_reg(out_reg),
    .out_seq(out_seq), .count(count), .full(full), .empty(empty),
    .overflow_count(overflow_count)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a record queue with drop counting
  typedef struct {
    logic [15:0] seq;
    logic [31:0] pc, instr, alu, wb;
  } mrec_t;

  mrec_t       mq[$];
  logic [15:0] m_seq = '0;
  logic [15:0] m_ovf = '0;

  task automatic model_step();
    mrec_t r;
    if (!reset) begin
      mq.delete();
      m_seq = '0;
      m_ovf = '0;
    end else begin
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (capture_en) begin
        if (mq.size() < DEPTH) begin
          r.seq = m_seq; r.pc = program_counter; r.instr = instruction;
          r.alu = alu_result; r.wb = reg_mem;
          mq.push_back(r);
        end else if (m_ovf != 16'hFFFF) begin
          m_ovf = m_ovf + 16'd1;
        end
        m_seq = m_seq + 16'd1;
      end
    end
  endtask

  always @(posedge clock) model_step();

  // Per-cycle comparison of every output against the model
  always @(negedge clock) begin
    if (chk_en) begin
      check("count", 64'(count), 64'(mq.size()));
      check("full", 64'(full), 64'(mq.size() == DEPTH));
      check("empty", 64'(empty), 64'(mq.size() == 0));
      check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      check("overflow_count", 64'(overflow_count), 64'(m_ovf));
      if (mq.size() != 0) begin
        check("out_seq", 64'(out_seq), 64'(mq[0].seq));
        check("out_pc", 64'(out_pc), 64'(mq[0].pc));
        check("out_instr", 64'(out_instr), 64'(mq[0].instr));
        check("out_alu", 64'(out_alu), 64'(mq[0].alu));
        check("out_reg", 64'(out_reg), 64'(mq[0].wb));
      end else begin
        check("out_zero", {out_pc, out_instr | out_alu | out_reg | 32'(out_seq)}, 64'd0);
      end
    end
  end

  task automatic step();
    @(negedge clock);
  endtask

  task automatic cap(input logic [31:0] pc, input logic [31:0] ins,
                     input logic [31:0] alu, input logic [31:0] wb);
    capture_en = 1'b1; program_counter = pc; instruction = ins;
    alu_result = alu; reg_mem = wb;
    step();
    capture_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++)
      cap(32'(i * 4), 32'hA000_0000 | 32'(i), 32'(i * 3), ~32'(i));
  endtask

  initial begin
    logic [15:0] prev;
    int          wraps;

    reset = 1'b0; capture_en = 1'b1; out_ready = 1'b0;
    program_counter = 32'h1234; instruction = 32'h5678;
    alu_result = 32'h9ABC; reg_mem = 32'hDEF0;

    // Reset held two clocks with capture requested
    step();
    chk_en = 1'b1;
    step();
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_pc", 64'(out_pc), 64'd0);
    check("rst_ovf", 64'(overflow_count), 64'd0);
    reset = 1'b1; capture_en = 1'b0;
    step();

    // Single record, then a one-clock drain
    cap(32'h0000_0004, 32'h8C01_0000, 32'h0000_0010, 32'h0000_0005);
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_pc", 64'(out_pc), 64'h4);
    check("single_instr", 64'(out_instr), 64'h8C01_0000);
    check("single_alu", 64'(out_alu), 64'h10);
    check("single_reg", 64'(out_reg), 64'h5);
    check("single_seq", 64'(out_seq), 64'd0);
    check("single_count", 64'(count), 64'd1);
    step();
    check("single_hold_pc", 64'(out_pc), 64'h4);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("single_drained_empty", 64'(empty), 64'd1);
    check("single_drained_pc", 64'(out_pc), 64'd0);

    // Fill, overflow by three, drain in order
    do_reset();
    fill(16);
    check("fill_full", 64'(full), 64'd1);
    fill(3);
    check("ovf_count", 64'(count), 64'd16);
    check("ovf_ovf", 64'(overflow_count), 64'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_pc", 64'(out_pc), 64'(i * 4));
      check("drain_seq", 64'(out_seq), 64'(i));
      step();
    end
    out_ready = 1'b0;
    check("drain_empty", 64'(empty), 64'd1);
    check("drain_ovf_kept", 64'(overflow_count), 64'd3);

    // Push and pop on the same edge while full
    do_reset();
    fill(16);
    out_ready = 1'b1;
    cap(32'h0000_0100, 32'h0, 32'h0, 32'h0);
    out_ready = 1'b0;
    check("pp_count", 64'(count), 64'd16);
    check("pp_ovf", 64'(overflow_count), 64'd0);
    check("pp_head_seq", 64'(out_seq), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) step();
    check("pp_tail_seq", 64'(out_seq), 64'd16);
    check("pp_tail_pc", 64'(out_pc), 64'h100);
    step();
    out_ready = 1'b0;

    // Reset in the middle of operation
    do_reset();
    fill(18);
    check("mid_ovf", 64'(overflow_count), 64'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) step();
    out_ready = 1'b0;
    check("mid_count", 64'(count), 64'd5);
    capture_en = 1'b1;
    do_reset();
    capture_en = 1'b0;
    check("mid_rst_empty", 64'(empty), 64'd1);
    check("mid_rst_ovf", 64'(overflow_count), 64'd0);
    cap(32'h0000_0200, 32'h1, 32'h2, 32'h3);
    check("mid_new_seq", 64'(out_seq), 64'd0);
    check("mid_new_count", 64'(count), 64'd1);

    // Sequence wrap across 65537 streamed captures
    do_reset();
    out_ready = 1'b1;
    capture_en = 1'b1;
    prev = 16'h0; wraps = 0;
    for (int i = 0; i < 65537; i++) begin
      program_counter = 32'(i); instruction = 32'(i) ^ 32'h5555_5555;
      alu_result = 32'(i) + 32'd7; reg_mem = 32'(i) << 1;
      step();
      if (i > 0 && prev == 16'hFFFF) begin
        check("wrap_seq", 64'(out_seq), 64'd0);
        wraps++;
      end
      prev = out_seq;
    end
    capture_en = 1'b0;
    step();
    out_ready = 1'b0;
    check("wrap_seen", 64'(wraps), 64'd1);
    check("wrap_ovf", 64'(overflow_count), 64'd0);
    check("wrap_empty", 64'(empty), 64'd1);
    step();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

endmodule
